// File: rtl/ub_ctrl_pkg.sv
// Shared types and constants for the unified-buffer port controller.
package ub_ctrl_pkg;

    localparam int NDIM   = 3;
    localparam int CTRL_W = 16;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        DELAY,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ub_dim_counter.sv
// One dimension of the affine loop nest: counts 0..EXT-1 and flags the wrap.
module ub_dim_counter #(
    parameter int W   = 16,
    parameter int EXT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] val,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(EXT - 1);

    // last is qualified by inc so it can feed the next dimension's inc directly.
    assign last = inc && (val == LAST_VAL);

    // Index register: clears on flush, wraps to 0 after EXT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (inc) begin
            val <= last ? '0 : val + 1'b1;
        end
    end

endmodule

// File: rtl/ub_affine_port_ctrl.sv
// Schedule-driven initiator for one unified-buffer port: walks a 3-deep
// affine loop nest at a fixed II and issues en / ctrl_vars / addr.
module ub_affine_port_ctrl
    import ub_ctrl_pkg::*;
#(
    parameter int W            = 16,
    parameter int EXT0         = 1,
    parameter int EXT1         = 64,
    parameter int EXT2         = 64,
    parameter int II           = 1,
    parameter int START_OFFSET = 0,
    parameter int ADDR_BASE    = 0,
    parameter int AS0          = 0,
    parameter int AS1          = 1,
    parameter int AS2          = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    output logic         en,
    output logic [W-1:0] ctrl_vars [NDIM-1:0],
    output logic [W-1:0] addr,
    output logic         done
);

    localparam logic [W-1:0] LAST0     = W'(EXT0 - 1);
    localparam logic [W-1:0] LAST1     = W'(EXT1 - 1);
    localparam logic [W-1:0] LAST2     = W'(EXT2 - 1);
    localparam logic [W-1:0] II_LAST   = W'(II - 1);
    localparam logic [W-1:0] DELAY_END = W'(START_OFFSET);
    localparam logic [W-1:0] BASE      = W'(ADDR_BASE);
    // Address deltas for an inner step, a dim-2 wrap and a dim-1 wrap.
    localparam logic [W-1:0] STEP2 = W'(AS2);
    localparam logic [W-1:0] STEP1 = W'(AS1 - (EXT2 - 1) * AS2);
    localparam logic [W-1:0] STEP0 = W'(AS0 - (EXT1 - 1) * AS1 - (EXT2 - 1) * AS2);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    delay_cnt;
    logic [W-1:0]    ii_cnt;
    logic [W-1:0]    cnt [NDIM-1:0];
    logic [NDIM-1:0] last;
    logic            final_iter;
    logic            advance;

    assign final_iter = (cnt[0] == LAST0) && (cnt[1] == LAST1) && (cnt[2] == LAST2);
    // The final iteration leaves the counters parked on their last values.
    assign advance    = en && !final_iter;

    ub_dim_counter #(.W(W), .EXT(EXT2)) u_dim2 (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .inc  (advance),
        .val  (cnt[2]),
        .last (last[2])
    );

    ub_dim_counter #(.W(W), .EXT(EXT1)) u_dim1 (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .inc  (last[2]),
        .val  (cnt[1]),
        .last (last[1])
    );

    ub_dim_counter #(.W(W), .EXT(EXT0)) u_dim0 (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .inc  (last[1]),
        .val  (cnt[0]),
        .last (last[0])
    );

    assign ctrl_vars = cnt;

    // State register; flush restarts the schedule from DELAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DELAY;
        end else if (flush) begin
            state <= DELAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: delay_cnt == START_OFFSET on an edge means the
    // following cycle is cycle START_OFFSET, the first issue cycle.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational (no latch).
        state_nxt = state;
        case (state)
            DELAY:   if (delay_cnt == DELAY_END) state_nxt = RUN;
            RUN:     if (en && final_iter)       state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = DELAY;
        endcase
    end

    // Outputs decoded from registers only, so flush never reaches them combinationally.
    always_comb begin
        en   = (state == RUN) && (ii_cnt == '0);
        done = (state == DONE);
    end

    // Start-offset and initiation-interval counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt <= '0;
            ii_cnt    <= '0;
        end else if (flush) begin
            delay_cnt <= '0;
            ii_cnt    <= '0;
        end else begin
            if (state == DELAY) begin
                delay_cnt <= delay_cnt + 1'b1;
            end
            if (state == RUN) begin
                ii_cnt <= (ii_cnt == II_LAST) ? '0 : ii_cnt + 1'b1;
            end
        end
    end

    // Incremental address: the innermost dimension that does not wrap picks the delta.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= BASE;
        end else if (flush) begin
            addr <= BASE;
        end else if (advance) begin
            if (!last[2]) begin
                addr <= addr + STEP2;
            end else if (!last[1]) begin
                addr <= addr + STEP1;
            end else begin
                addr <= addr + STEP0;
            end
        end
    end

endmodule

// File: tb/tb_ub_affine_port_ctrl.sv
// Self-checking bench: four controller instances with different schedules,
// each compared against an independent iteration model through a queue.
module tb_ub_affine_port_ctrl;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v   [4];
    logic        flush_v [4];
    logic        en_v    [4];
    logic        done_v  [4];
    logic [15:0] addr_v  [4];
    logic [15:0] cv_a [2:0];
    logic [15:0] cv_b [2:0];
    logic [15:0] cv_c [2:0];
    logic [15:0] cv_d [2:0];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Default geometry, first enable four cycles after release.
    ub_affine_port_ctrl #(.W(16), .START_OFFSET(4)) dut_a (
        .clk(clk), .rst_n(rst_v[0]), .flush(flush_v[0]), .en(en_v[0]),
        .ctrl_vars(cv_a), .addr(addr_v[0]), .done(done_v[0]));

    // II of 3 over a 1x2x2 nest.
    ub_affine_port_ctrl #(.W(16), .EXT0(1), .EXT1(2), .EXT2(2), .II(3), .START_OFFSET(0)) dut_b (
        .clk(clk), .rst_n(rst_v[1]), .flush(flush_v[1]), .en(en_v[1]),
        .ctrl_vars(cv_b), .addr(addr_v[1]), .done(done_v[1]));

    // Single-iteration nest.
    ub_affine_port_ctrl #(.W(16), .EXT0(1), .EXT1(1), .EXT2(1), .START_OFFSET(0)) dut_c (
        .clk(clk), .rst_n(rst_v[2]), .flush(flush_v[2]), .en(en_v[2]),
        .ctrl_vars(cv_c), .addr(addr_v[2]), .done(done_v[2]));

    // Address wrap modulo 2^16.
    ub_affine_port_ctrl #(.W(16), .EXT0(1), .EXT1(4), .EXT2(2), .START_OFFSET(0),
                          .AS1(16'hFFFF), .AS2(2)) dut_d (
        .clk(clk), .rst_n(rst_v[3]), .flush(flush_v[3]), .en(en_v[3]),
        .ctrl_vars(cv_d), .addr(addr_v[3]), .done(done_v[3]));

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] sample(input int d, input int cyc);
        logic [15:0] cv [2:0];
        case (d)
            0:       cv = cv_a;
            1:       cv = cv_b;
            2:       cv = cv_c;
            default: cv = cv_d;
        endcase
        return {32'(cyc), cv[0], cv[1], cv[2], addr_v[d]};
    endfunction

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s_d%0d_en", tag, d), {95'd0, en_v[d]}, 96'd0);
        check($sformatf("%s_d%0d_done", tag, d), {95'd0, done_v[d]}, 96'd0);
        check($sformatf("%s_d%0d_vars_addr", tag, d), sample(d, 0), 96'd0);
    endtask

    // Push the model's full enable schedule, then follow the DUT cycle by cycle.
    // Call at a negedge right after reset/flush release: the next posedge is cycle 0.
    task automatic run_sched(input int d, input int e0, input int e1, input int e2,
                             input int ii, input int s, input int base, input int as0,
                             input int as1, input int as2, input bit check_end, input int ncyc);
        int   n;
        int   done_cyc;
        exp_t e;
        exp_q.delete();
        n = e0 * e1 * e2;
        for (int k = 0; k < n; k++) begin
            e.cyc  = 32'(s + k * ii);
            e.c0   = 16'(k / (e1 * e2));
            e.c1   = 16'((k / e2) % e1);
            e.c2   = 16'(k % e2);
            e.addr = 16'(base + int'(e.c0) * as0 + int'(e.c1) * as1 + int'(e.c2) * as2);
            exp_q.push_back(e);
        end
        done_cyc = s + (n - 1) * ii + 1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("d%0d_done_c%0d", d, cyc), {95'd0, done_v[d]},
                  {95'd0, (cyc >= done_cyc)});
            if (en_v[d]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("d%0d_extra_en_c%0d", d, cyc), {95'd0, en_v[d]}, 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("d%0d_issue_c%0d", d, cyc), sample(d, cyc), e);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                check($sformatf("d%0d_missing_en_c%0d", d, cyc), {95'd0, en_v[d]}, 96'd1);
                void'(exp_q.pop_front());
            end
        end
        if (check_end) begin
            check($sformatf("d%0d_remaining", d), 96'(exp_q.size()), 96'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_v[i]   = 1'b0;
            flush_v[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 4; i++) check_idle(i, "reset");

        // Default nest: en in cycles 4..4099, done from 4100.
        @(negedge clk);
        rst_v[0] = 1'b1;
        run_sched(0, 1, 64, 64, 1, 4, 0, 0, 1, 64, 1'b1, 4102);

        // Flush out of DONE, then a flush held for three edges at cycle 50.
        flush_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(0, "flush_done");
        flush_v[0] = 1'b0;
        run_sched(0, 1, 64, 64, 1, 4, 0, 0, 1, 64, 1'b0, 50);
        flush_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_idle(0, $sformatf("flush_hold%0d", i));
        end
        flush_v[0] = 1'b0;
        run_sched(0, 1, 64, 64, 1, 4, 0, 0, 1, 64, 1'b1, 4102);

        // Asynchronous reset from DONE and from mid-run at cycle 200.
        #1 rst_v[0] = 1'b0;
        #1 check_idle(0, "async_rst_done");
        @(negedge clk);
        rst_v[0] = 1'b1;
        run_sched(0, 1, 64, 64, 1, 4, 0, 0, 1, 64, 1'b0, 200);
        check("pre_rst_en", {95'd0, en_v[0]}, 96'd1);
        #1 rst_v[0] = 1'b0;
        #1 check_idle(0, "async_rst_run");
        @(posedge clk);
        @(negedge clk);
        check_idle(0, "rst_held");
        rst_v[0] = 1'b1;
        run_sched(0, 1, 64, 64, 1, 4, 0, 0, 1, 64, 1'b1, 4102);

        // II=3: en in cycles 0,3,6,9, done from cycle 10.
        rst_v[1] = 1'b1;
        run_sched(1, 1, 2, 2, 3, 0, 0, 0, 1, 64, 1'b1, 13);

        // Single iteration, then a flush re-issues exactly one enable.
        rst_v[2] = 1'b1;
        run_sched(2, 1, 1, 1, 1, 0, 0, 0, 1, 64, 1'b1, 4);
        flush_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(2, "single_flush");
        flush_v[2] = 1'b0;
        run_sched(2, 1, 1, 1, 1, 0, 0, 0, 1, 64, 1'b1, 4);

        // Address wrap: 0, 2, 0xFFFF, 1, 0xFFFE, 0, 0xFFFD, 0xFFFF.
        rst_v[3] = 1'b1;
        run_sched(3, 1, 4, 2, 1, 0, 0, 0, 16'hFFFF, 2, 1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
